noc_pkt_inject: RTL and testbench

// - Synthesizable packet injector for a router's local input port (p0); it replaces the bench-side send task.
// - Accepts packet requests (dst, vch, len), queues them, and builds HEAD/DATA/TAIL (or HEADTAIL) flits.
// - Applies packet-level flow control on the router's per-VC ready vector, then streams the flits into idata/ivalid/ivch.

---
 rtl/noc_pkg.sv | 47 ++++
 rtl/noc_req_fifo.sv | 54 +++++
 rtl/noc_pkt_inject.sv | 168 ++++++++++++++++
 tb/tb_noc_pkt_inject.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the NoC packet injector.
// - flit_type_e : 2-bit flit type codes carried in the TYPE field.
// - *_LSB/*_MSB : flit field positions (HEAD uses DST/SRC/VCH, body flits use IDX/TS).
// - flit_t      : 32-bit flit layout; the [15:12] tag holds VCH on HEAD and idx on body flits.
// - pkt_req_t   : queued packet request {dst, vch, len}, sized for the widest supported config.
package noc_pkg;

  typedef enum logic [1:0] {
    FlitData     = 2'd0,
    FlitHead     = 2'd1,
    FlitTail     = 2'd2,
    FlitHeadTail = 2'd3
  } flit_type_e;

  localparam int unsigned TYPE_LSB = 0;
  localparam int unsigned TYPE_MSB = 1;
  localparam int unsigned DST_LSB  = 4;
  localparam int unsigned DST_MSB  = 7;
  localparam int unsigned SRC_LSB  = 8;
  localparam int unsigned SRC_MSB  = 11;
  localparam int unsigned VCH_LSB  = 12;
  localparam int unsigned VCH_MSB  = 15;
  localparam int unsigned IDX_LSB  = 12;
  localparam int unsigned IDX_MSB  = 15;
  localparam int unsigned TS_LSB   = 16;
  localparam int unsigned TS_MSB   = 31;

  // Request fields are stored at their maximum widths; the top truncates on read.
  localparam int unsigned REQ_VCHW = 4;
  localparam int unsigned REQ_LENW = 16;

  typedef struct packed {
    logic [15:0] ts;
    logic [3:0]  tag;
    logic [3:0]  src;
    logic [3:0]  dst;
    logic [1:0]  rsvd;
    flit_type_e  ftype;
  } flit_t;

  typedef struct packed {
    logic [3:0]          dst;
    logic [REQ_VCHW-1:0] vch;
    logic [REQ_LENW-1:0] len;
  } pkt_req_t;

endpackage

// File: rtl/noc_req_fifo.sv
// Synchronous FIFO of packet requests.
// Ports: clk, rst_ (sync active-high), push/wdata, pop/rdata, full, empty, count.
// A push while full is refused even when a pop happens on the same edge.
module noc_req_fifo
  import noc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     push,
  input  pkt_req_t                 wdata,
  input  logic                     pop,
  output pkt_req_t                 rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam logic [PTRW:0] FULL_CNT = DEPTH[PTRW:0];

  pkt_req_t        mem_q [DEPTH];
  logic [PTRW-1:0] wptr_q, rptr_q;
  logic [PTRW:0]   count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/noc_pkt_inject.sv
// Packet injector for a router's local input port.
// Ports: clk, rst_ (sync active-high); req_valid/req_ready/req_dst/req_vch/req_len request
// interface; ordy per-VC router ready; odata/ovalid/ovch flit stream; busy; flit_cnt,
// pkt_cnt, drop_cnt statistics.
module noc_pkt_inject
  import noc_pkg::*;
#(
  parameter int unsigned FLITW     = 32,
  parameter int unsigned VCH_NUM   = 2,
  parameter int unsigned SRC_ID    = 0,
  parameter int unsigned REQ_DEPTH = 4,
  parameter int unsigned LENW      = 6,
  localparam int unsigned VCHW     = (VCH_NUM > 1) ? $clog2(VCH_NUM) : 1
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_dst,
  input  logic [VCHW-1:0]    req_vch,
  input  logic [LENW-1:0]    req_len,
  input  logic [VCH_NUM-1:0] ordy,
  output logic [FLITW-1:0]   odata,
  output logic               ovalid,
  output logic [VCHW-1:0]    ovch,
  output logic               busy,
  output logic [31:0]        flit_cnt,
  output logic [31:0]        pkt_cnt,
  output logic [15:0]        drop_cnt
);

  typedef enum logic [1:0] {StIdle, StWait, StSend} state_e;

  state_e                      state_q, state_d;
  logic [3:0]                  dst_q;
  logic [VCHW-1:0]             vch_q;
  logic [LENW-1:0]             len_q, idx_q, idx_d;
  logic [15:0]                 ts_q, timestamp_q;
  logic [FLITW-1:0]            odata_q;
  logic                        ovalid_q;
  logic [VCHW-1:0]             ovch_q;
  logic [31:0]                 flit_cnt_q, pkt_cnt_q;
  logic [15:0]                 drop_cnt_q;

  pkt_req_t                    fifo_wdata, fifo_rdata;
  logic                        fifo_full, fifo_empty;
  logic [$clog2(REQ_DEPTH):0]  fifo_count;
  logic [LENW-1:0]             rd_len;
  logic                        pop, latch, drop, emit, last, free;
  flit_t                       flit_d;
  logic                        unused_rdata;

  assign fifo_wdata.dst = req_dst;
  assign fifo_wdata.vch = REQ_VCHW'(req_vch);
  assign fifo_wdata.len = REQ_LENW'(req_len);
  assign rd_len         = fifo_rdata.len[LENW-1:0];
  assign unused_rdata   = ^{fifo_rdata.vch, fifo_rdata.len};

  noc_req_fifo #(
    .DEPTH (REQ_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_  (rst_),
    .push  (req_valid),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign req_ready = !fifo_full;
  assign busy      = (fifo_count != '0) || (state_q != StIdle);
  assign odata     = odata_q;
  assign ovalid    = ovalid_q;
  assign ovch      = ovch_q;
  assign flit_cnt  = flit_cnt_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign drop_cnt  = drop_cnt_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    latch   = 1'b0;
    drop    = 1'b0;
    emit    = 1'b0;
    last    = 1'b0;
    free    = 1'b0;
    flit_d  = '0;
    unique case (state_q)
      StIdle: free = 1'b1;
      StWait: begin
        // Packet-level flow control: only the HEAD waits on ordy.
        if (ordy[vch_q]) begin
          emit         = 1'b1;
          flit_d.ftype = (len_q == LENW'(1)) ? FlitHeadTail : FlitHead;
          flit_d.dst   = dst_q;
          flit_d.src   = 4'(SRC_ID);
          flit_d.tag   = 4'(vch_q);
          idx_d        = LENW'(1);
          if (len_q == LENW'(1)) last = 1'b1;
          else                   state_d = StSend;
        end
      end
      StSend: begin
        emit         = 1'b1;
        last         = (idx_q == len_q - 1'b1);
        flit_d.ftype = last ? FlitTail : FlitData;
        flit_d.tag   = idx_q[3:0];
        flit_d.ts    = ts_q;
        idx_d        = idx_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // The edge carrying the last flit may already pop the next request.
    free = free | last;
    if (free) begin
      state_d = StIdle;
      if (!fifo_empty) begin
        pop = 1'b1;
        if (rd_len == '0) begin
          drop = 1'b1;
        end else begin
          latch   = 1'b1;
          state_d = StWait;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q     <= StIdle;
      dst_q       <= '0;
      vch_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      ts_q        <= '0;
      timestamp_q <= '0;
      odata_q     <= '0;
      ovalid_q    <= 1'b0;
      ovch_q      <= '0;
      flit_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timestamp_q <= timestamp_q + 1'b1;
      ovalid_q    <= emit;
      odata_q     <= emit ? FLITW'(flit_d) : '0;
      ovch_q      <= emit ? vch_q : '0;
      if (latch) begin
        dst_q <= fifo_rdata.dst;
        vch_q <= fifo_rdata.vch[VCHW-1:0];
        len_q <= rd_len;
        ts_q  <= timestamp_q;
      end
      if (emit) flit_cnt_q <= flit_cnt_q + 32'd1;
      if (last) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_noc_pkt_inject.sv
// Self-checking bench for noc_pkt_inject: directed scenarios plus randomized traffic,
// scored against a packet-level reference model (request queue + expected flit contents).
module tb_noc_pkt_inject;
  import noc_pkg::*;

  localparam int unsigned FLITW = 32;
  localparam int unsigned VCH_NUM = 2;
  localparam int unsigned SRC_ID = 0;
  localparam int unsigned REQ_DEPTH = 4;
  localparam int unsigned LENW = 6;
  localparam int unsigned VCHW = 1;

  logic               clk = 1'b0;
  logic               rst_ = 1'b1;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [3:0]         req_dst = '0;
  logic [VCHW-1:0]    req_vch = '0;
  logic [LENW-1:0]    req_len = '0;
  logic [VCH_NUM-1:0] ordy = '0;
  logic [FLITW-1:0]   odata;
  logic               ovalid;
  logic [VCHW-1:0]    ovch;
  logic               busy;
  logic [31:0]        flit_cnt, pkt_cnt;
  logic [15:0]        drop_cnt;

  noc_pkt_inject #(
    .FLITW     (FLITW),
    .VCH_NUM   (VCH_NUM),
    .SRC_ID    (SRC_ID),
    .REQ_DEPTH (REQ_DEPTH),
    .LENW      (LENW)
  ) dut (
    .clk       (clk),
    .rst_      (rst_),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dst   (req_dst),
    .req_vch   (req_vch),
    .req_len   (req_len),
    .ordy      (ordy),
    .odata     (odata),
    .ovalid    (ovalid),
    .ovch      (ovch),
    .busy      (busy),
    .flit_cnt  (flit_cnt),
    .pkt_cnt   (pkt_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      dst;
    logic [VCHW-1:0] vch;
    int              len;
    int              acc;
  } req_t;

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  req_t        req_q[$];
  req_t        cur;
  bit          in_pkt = 0;
  int          idx, pop_e, free_e, head_edge, last_tail_e, b2b;
  int          flit_exp, pkt_exp, drop_exp;
  logic [15:0] ts_exp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Expected flit from the flit-format rules.
  function automatic logic [31:0] model_flit(input req_t r, input int i, input logic [15:0] ts);
    logic [1:0] t;
    if (i == 0) begin
      t = (r.len == 1) ? FlitHeadTail : FlitHead;
      return {16'd0, 4'(r.vch), 4'(SRC_ID), r.dst, 2'b00, t};
    end
    t = (i == r.len - 1) ? FlitTail : FlitData;
    return {ts, 4'(i % 16), 8'd0, 2'b00, t};
  endfunction

  // A request is popped at max(accept+1, first edge the engine is free); drops cost one edge.
  function automatic void drain_drops();
    int p;
    while (req_q.size() > 0 && req_q[0].len == 0) begin
      p = (req_q[0].acc + 1 > free_e) ? req_q[0].acc + 1 : free_e;
      free_e = p + 1;
      drop_exp++;
      void'(req_q.pop_front());
    end
  endfunction

  always @(posedge clk) begin
    if (rst_) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Output monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_) begin
      req_q.delete();
      in_pkt = 0; free_e = 0; flit_exp = 0; pkt_exp = 0; drop_exp = 0;
      last_tail_e = -10; b2b = 0;
    end else begin
      if (in_pkt) begin
        check("flit_continuous", ovalid, 1);
        if (!ovalid) in_pkt = 0;
      end
      if (ovalid) begin
        flit_exp++;
        if (!in_pkt) begin
          drain_drops();
          check("head_has_request", 64'(req_q.size() > 0), 1);
          if (req_q.size() > 0) begin
            cur = req_q.pop_front();
            pop_e = (cur.acc + 1 > free_e) ? cur.acc + 1 : free_e;
            ts_exp = 16'(pop_e - 1);
            idx = 0; in_pkt = 1; head_edge = cyc;
            if (cyc - last_tail_e == 1) b2b++;
            check("head_after_pop", 64'(cyc > pop_e), 1);
          end
        end
        if (in_pkt) begin
          check("odata", odata, model_flit(cur, idx, ts_exp));
          check("ovch", ovch, cur.vch);
          if (idx == cur.len - 1) begin
            pkt_exp++; in_pkt = 0; free_e = cyc; last_tail_e = cyc;
          end else begin
            idx++;
          end
        end
      end
      if (req_valid && req_ready) req_q.push_back('{req_dst, req_vch, int'(req_len), cyc + 1});
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_ = 1'b1; req_valid = 1'b0; ordy = '0;
    repeat (2) @(posedge clk);
    #1 rst_ = 1'b0;
  endtask

  task automatic send_req(input int d, input int v, input int l, input bit rnd, output int acc);
    bit ok = 0;
    req_dst = 4'(d); req_vch = VCHW'(v); req_len = LENW'(l); req_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (req_ready) begin ok = 1; break; end
      @(posedge clk); #1;
      if (rnd) ordy = VCH_NUM'($urandom);
    end
    check("req_accepted", ok, 1);
    acc = cyc + 1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    ordy = '1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (!busy && !ovalid) begin ok = 1; break; end
    end
    check("drain_idle", ok, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, rel, l;
    bit seen;

    // Reset state
    do_reset();
    check("rst_ovalid", ovalid, 0);
    check("rst_odata", odata, 0);
    check("rst_ovch", ovch, 0);
    check("rst_busy", busy, 0);
    check("rst_flit_cnt", flit_cnt, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_req_ready", req_ready, 1);

    // Single 5-flit packet, HEAD two edges after accept
    ordy = 2'b11;
    send_req(4, 0, 5, 0, acc);
    wait_idle();
    check("single_head_latency", head_edge, acc + 2);
    check("single_flit_cnt", flit_cnt, 5);
    check("single_pkt_cnt", pkt_cnt, 1);

    // len==1 -> HEADTAIL
    do_reset();
    ordy = 2'b11;
    send_req(2, 1, 1, 0, acc);
    wait_idle();
    check("ht_flit_cnt", flit_cnt, 1);
    check("ht_pkt_cnt", pkt_cnt, 1);

    // Blocked VC1 for 10 cycles while ordy[0] toggles
    do_reset();
    ordy = 2'b01;
    send_req(7, 1, 3, 0, acc);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      ordy = {1'b0, 1'(i)};
      check("blocked_idle", ovalid, 0);
    end
    ordy = 2'b11;
    rel = cyc;
    wait_idle();
    check("blocked_head_time", head_edge, rel + 1);
    check("blocked_pkt_cnt", pkt_cnt, 1);

    // FIFO full: 4 queued + 1 waiting, 6th held until ordy releases
    do_reset();
    ordy = 2'b00;
    for (int i = 0; i < 5; i++) send_req(i, 0, 2, 0, acc);
    check("full_req_ready", req_ready, 0);
    req_dst = 4'd5; req_vch = '0; req_len = LENW'(2); req_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("full_held", req_ready, 0);
    end
    ordy = 2'b11;
    send_req(5, 0, 2, 0, acc);
    wait_idle();
    check("full_pkt_cnt", pkt_cnt, 6);
    check("full_flit_cnt", flit_cnt, 12);
    check("full_b2b_heads", b2b, 5);

    // len==0 drop, then reset in the middle of a len=8 packet
    do_reset();
    ordy = 2'b11;
    send_req(3, 0, 0, 0, acc);
    wait_idle();
    check("drop_cnt", drop_cnt, 1);
    check("drop_no_flits", flit_cnt, 0);
    send_req(1, 1, 8, 0, acc);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ovalid) begin seen = 1; break; end
    end
    repeat (2) @(posedge clk);
    #1 check("mid_pkt_valid", 64'(seen && ovalid), 1);
    rst_ = 1'b1;
    @(posedge clk); #1;
    check("abort_ovalid", ovalid, 0);
    check("abort_odata", odata, 0);
    check("abort_flit_cnt", flit_cnt, 0);
    check("abort_pkt_cnt", pkt_cnt, 0);
    check("abort_drop_cnt", drop_cnt, 0);
    check("abort_busy", busy, 0);
    rst_ = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_tail", ovalid, 0);
    end

    // Randomized traffic with random per-VC ready
    do_reset();
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        ordy = VCH_NUM'($urandom);
      end
      l = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 24)) : int'($urandom_range(0, 6));
      send_req(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), l, 1, acc);
    end
    wait_idle();
    drain_drops();
    check("rand_flit_cnt", flit_cnt, flit_exp);
    check("rand_pkt_cnt", pkt_cnt, pkt_exp);
    check("rand_drop_cnt", drop_cnt, drop_exp);
    check("rand_queue_empty", req_q.size(), 0);
    check("rand_no_open_pkt", in_pkt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
